multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle control unit of the reduced RISC-V core. One FSM sequences fetch, decode, execute, memory and writeback over a single shared instruction/data memory that answers with a ready handshake. It supports addi, beq, bne, lw and sw. Any other opcode drives the core into a sticky halt.

Parameters:
INSTR_LEN, 32, instruction width; opcode is bits [6:0], funct3 is bits [14:12].
ALUCTRL_W, 3, width of ALUctrl.
IMMSRC_W, 2, width of Immsrc.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
instr  in  INSTR_LEN  instruction register contents; stable from DECODE until the next IRwrite.
EQ  in  1  ALU equality flag.
mem_ready  in  1  memory has completed the current read or write.
RegWrite  out  1  register file write strobe.
ALUctrl  out  ALUCTRL_W  000=add, 001=sub.
ALUsrc  out  1  0=rs2, 1=immediate.
Immsrc  out  IMMSRC_W  00=I-type, 01=B-type, 10=S-type.
PCsrc  out  1  0=PC+4, 1=PC+immB.
PCwrite  out  1  PC register enable.
IRwrite  out  1  instruction register enable.
AdrSrc  out  1  memory address source: 0=PC, 1=ALU result.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
ResultSrc  out  1  writeback source: 0=ALU, 1=memory data.
illegal  out  1  sticky flag: an unsupported instruction was decoded.

Behaviour:
- Outputs not listed for a state are 0.
- ALUctrl, ALUsrc and Immsrc hold their EXEC/MEM_ADR values through the MEM_*/WB_* states. This keeps the combinational ALU result stable, because the datapath has no ALUOut register.
- Reset:
  - rst=1 at an edge sets state=FETCH and clears illegal.
  - While rst=1, RegWrite, MemRead, MemWrite, PCwrite and IRwrite are forced to 0, whatever the state.
  - rst mid-transaction abandons the transaction; no write strobe leaks out.
- FETCH:
  - AdrSrc=0, MemRead=1; wait here while mem_ready=0.
  - On mem_ready=1: IRwrite=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0010011 -> EXEC_I.
  - 1100011 -> BRANCH.
  - 0000011 or 0100011 -> MEM_ADR.
  - Any other opcode -> HALT.
- EXEC_I:
  - ALUctrl=000; Immsrc=00.
  - ALUsrc=1 when funct3=000, else ALUsrc=0 (the write still occurs).
  - Go to WB_ALU.
- WB_ALU: RegWrite=1, ResultSrc=0, PCwrite=1, PCsrc=0; go to FETCH.
- BRANCH:
  - ALUctrl=001, ALUsrc=0, Immsrc=01, PCwrite=1.
  - PCsrc = EQ for funct3=000, ~EQ for funct3=001, 0 for any other funct3.
  - PCsrc is combinational on EQ in this state only. Go to FETCH.
- MEM_ADR:
  - ALUctrl=000, ALUsrc=1.
  - Immsrc=00 for lw, 10 for sw.
  - Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: AdrSrc=1, MemRead=1; wait on mem_ready; then go to WB_MEM.
- WB_MEM: RegWrite=1, ResultSrc=1, PCwrite=1, PCsrc=0; go to FETCH.
- MEM_WR:
  - AdrSrc=1; MemWrite=1 held until mem_ready=1.
  - On mem_ready=1: PCwrite=1 in the same cycle, then go to FETCH.
- HALT: illegal=1; all strobes 0; remains here until rst.
- Latency at mem_ready=1 with no wait states:
  - addi: 4 cycles.
  - branch: 3 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Each cycle mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Exactly one PCwrite pulse per retired instruction.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, EXEC_I, BRANCH, MEM_ADR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, HALT.
  - Opcode constants.
  - funct3 constants.
  - ALUctrl codes.
  - Immsrc codes.
- One combinational sub-module, instr_decoder, maps opcode/funct3 to the next state after DECODE plus the ALUctrl, ALUsrc and Immsrc values.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> IRwrite in cycle 1, RegWrite=1 and PCwrite=1 in cycle 4 (WB_ALU), ALUsrc=1, ALUctrl=000.
- beq 0x00000463 with EQ=1, then EQ=0 -> BRANCH cycle has PCwrite=1 with PCsrc=1, then PCsrc=0; bne 0x00009463 gives the inverse.
- lw x2,0(x0) (0x00002103) with mem_ready low for 2 cycles in MEM_RD -> MemRead and AdrSrc=1 held for 3 cycles; RegWrite=1 with ResultSrc=1 in the next cycle; total 7 cycles.
- sw x1,4(x0) (0x00102223), mem_ready=1 -> Immsrc=10 in MEM_ADR, exactly one MemWrite cycle, PCwrite coincident with it, RegWrite never asserted.
- Opcode 0x0000007F -> illegal=1 from HALT on, no further strobes for 20 cycles; rst clears illegal and the next cycle is FETCH.
- rst asserted during a stalled MEM_WR -> MemWrite=0 in that cycle, FETCH afterwards, no PCwrite.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXEC_I,
      BRANCH,
      MEM_ADR,
      MEM_RD,
      MEM_WR,
      WB_ALU,
      WB_MEM,
      HALT
   } state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_B = 2'b01;
   localparam logic [1:0] IMM_S = 2'b10;

endpackage

// File: rtl/instr_decoder.sv
// Opcode/funct3 decode: state after DECODE and the ALU/immediate controls
// that stay applied for the whole execution of the instruction.
module instr_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int IMMSRC_W  = 2
) (
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   output state_t               next_state,
   output logic [ALUCTRL_W-1:0] aluctrl,
   output logic                 alusrc,
   output logic [IMMSRC_W-1:0]  immsrc
);

   // Per-opcode control decode; unknown opcodes route to HALT.
   always_comb begin
      next_state = HALT;
      aluctrl    = ALUCTRL_W'(ALU_ADD);
      alusrc     = 1'b0;
      immsrc     = IMMSRC_W'(IMM_I);
      case (opcode)
         OP_IMM: begin
            next_state = EXEC_I;
            alusrc     = (funct3 == F3_ADDI);
         end
         OP_BRANCH: begin
            next_state = BRANCH;
            aluctrl    = ALUCTRL_W'(ALU_SUB);
            immsrc     = IMMSRC_W'(IMM_B);
         end
         OP_LOAD: begin
            next_state = MEM_ADR;
            alusrc     = 1'b1;
         end
         OP_STORE: begin
            next_state = MEM_ADR;
            alusrc     = 1'b1;
            immsrc     = IMMSRC_W'(IMM_S);
         end
         default: next_state = HALT;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the reduced RISC-V core (addi/beq/bne/lw/sw)
// sharing one instruction/data memory with a ready handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | read instruction at PC, latch IR when memory is ready
// DECODE  | pick the execution path from the opcode
// EXEC_I  | immediate ALU operation
// BRANCH  | compare rs1/rs2, conditionally take PC+immB
// MEM_ADR | form load/store address
// MEM_RD  | load data read, wait on memory
// MEM_WR  | store data write, wait on memory, then advance PC
// WB_ALU  | write ALU result, advance PC
// WB_MEM  | write load data, advance PC
// HALT    | unsupported opcode seen, parked until reset
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int INSTR_LEN = 32,
   parameter int ALUCTRL_W = 3,
   parameter int IMMSRC_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INSTR_LEN-1:0] instr,
   input  logic                 EQ,
   input  logic                 mem_ready,
   output logic                 RegWrite,
   output logic [ALUCTRL_W-1:0] ALUctrl,
   output logic                 ALUsrc,
   output logic [IMMSRC_W-1:0]  Immsrc,
   output logic                 PCsrc,
   output logic                 PCwrite,
   output logic                 IRwrite,
   output logic                 AdrSrc,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 ResultSrc,
   output logic                 illegal
);

   state_t state_q;
   state_t state_d;
   state_t dec_next;

   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic [ALUCTRL_W-1:0] dec_aluctrl;
   logic                 dec_alusrc;
   logic [IMMSRC_W-1:0]  dec_immsrc;
   logic                 alu_hold;
   logic                 instr_unused;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign instr_unused = ^{instr[INSTR_LEN-1:15], instr[11:7]};

   instr_decoder #(
      .ALUCTRL_W (ALUCTRL_W),
      .IMMSRC_W  (IMMSRC_W)
   ) u_instr_decoder (
      .opcode     (opcode),
      .funct3     (funct3),
      .next_state (dec_next),
      .aluctrl    (dec_aluctrl),
      .alusrc     (dec_alusrc),
      .immsrc     (dec_immsrc)
   );

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   // There is no ALUOut register, so the ALU controls must stay applied from
   // the execute step through memory access and writeback.
   assign alu_hold = (state_q inside {EXEC_I, BRANCH, MEM_ADR, MEM_RD, MEM_WR,
                                      WB_ALU, WB_MEM});

   assign ALUctrl = alu_hold ? dec_aluctrl : '0;
   assign ALUsrc  = alu_hold ? dec_alusrc  : 1'b0;
   assign Immsrc  = alu_hold ? dec_immsrc  : '0;

   // HALT is only left through reset, so the state itself is the sticky flag.
   assign illegal = (state_q == HALT);

   // Next-state and strobe generation; reset masks every strobe so an
   // abandoned transaction cannot write anything.
   always_comb begin
      state_d   = state_q;
      RegWrite  = 1'b0;
      PCsrc     = 1'b0;
      PCwrite   = 1'b0;
      IRwrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ResultSrc = 1'b0;
      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRwrite = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: state_d = dec_next;
         EXEC_I: state_d = WB_ALU;
         BRANCH: begin
            PCwrite = 1'b1;
            case (funct3)
               F3_BEQ:  PCsrc = EQ;
               F3_BNE:  PCsrc = ~EQ;
               default: PCsrc = 1'b0;
            endcase
            state_d = FETCH;
         end
         MEM_ADR: state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
         MEM_RD: begin
            AdrSrc  = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) state_d = WB_MEM;
         end
         MEM_WR: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) begin
               PCwrite = 1'b1;
               state_d = FETCH;
            end
         end
         WB_ALU: begin
            RegWrite = 1'b1;
            PCwrite  = 1'b1;
            state_d  = FETCH;
         end
         WB_MEM: begin
            RegWrite  = 1'b1;
            ResultSrc = 1'b1;
            PCwrite   = 1'b1;
            state_d   = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
      if (rst) begin
         RegWrite = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         PCwrite  = 1'b0;
         IRwrite  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-cycle vector table
// followed by hand-written HALT and stalled-store sequences.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        EQ;
   logic        mem_ready;
   logic        RegWrite;
   logic [2:0]  ALUctrl;
   logic        ALUsrc;
   logic [1:0]  Immsrc;
   logic        PCsrc;
   logic        PCwrite;
   logic        IRwrite;
   logic        AdrSrc;
   logic        MemRead;
   logic        MemWrite;
   logic        ResultSrc;
   logic        illegal;

   multicycle_control_unit dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .EQ        (EQ),
      .mem_ready (mem_ready),
      .RegWrite  (RegWrite),
      .ALUctrl   (ALUctrl),
      .ALUsrc    (ALUsrc),
      .Immsrc    (Immsrc),
      .PCsrc     (PCsrc),
      .PCwrite   (PCwrite),
      .IRwrite   (IRwrite),
      .AdrSrc    (AdrSrc),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ResultSrc (ResultSrc),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   localparam logic        L    = 1'b0;
   localparam logic        H    = 1'b1;
   localparam logic [2:0]  ADD  = 3'b000;
   localparam logic [2:0]  SUB  = 3'b001;
   localparam logic [1:0]  IMI  = 2'b00;
   localparam logic [1:0]  IMB  = 2'b01;
   localparam logic [1:0]  IMS  = 2'b10;
   localparam logic [31:0] ADDI = 32'h0050_0093;
   localparam logic [31:0] SLTI = 32'h0050_2093;
   localparam logic [31:0] BEQ  = 32'h0000_0463;
   localparam logic [31:0] BNE  = 32'h0000_9463;
   localparam logic [31:0] LW   = 32'h0000_2103;
   localparam logic [31:0] SW   = 32'h0010_2223;
   localparam logic [31:0] ILL  = 32'h0000_007F;

   // {RegWrite, ALUctrl, ALUsrc, Immsrc, PCsrc, PCwrite, IRwrite, AdrSrc,
   //  MemRead, MemWrite, ResultSrc, illegal}
   logic [14:0] act;
   assign act = {RegWrite, ALUctrl, ALUsrc, Immsrc, PCsrc, PCwrite, IRwrite,
                 AdrSrc, MemRead, MemWrite, ResultSrc, illegal};

   function automatic logic [14:0] e(input logic rw, input logic [2:0] ac,
                                     input logic as, input logic [1:0] is,
                                     input logic pcs, input logic pcw,
                                     input logic irw, input logic adr,
                                     input logic mrd, input logic mwr,
                                     input logic res, input logic ill);
      return {rw, ac, as, is, pcs, pcw, irw, adr, mrd, mwr, res, ill};
   endfunction

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] instr;
      logic        eq;
      logic        rdy;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic add(input string name, input logic r, input logic [31:0] ins,
                      input logic eq, input logic rdy, input logic [14:0] exp);
      vec_t v;
      v.name = name; v.rst = r; v.instr = ins; v.eq = eq; v.rdy = rdy; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      logic [14:0] fe, ze, halt_e;
      int stalls, lat, pcw_n, mw_n, rw_n;
      bit done;

      fe     = e(L,ADD,L,IMI,L,L,H,L,H,L,L,L);
      ze     = e(L,ADD,L,IMI,L,L,L,L,L,L,L,L);
      halt_e = e(L,ADD,L,IMI,L,L,L,L,L,L,L,H);

      add("reset_hold",   H, ADDI, L, H, ze);
      add("addi_fetch",   L, ADDI, L, H, fe);
      add("addi_decode",  L, ADDI, L, H, ze);
      add("addi_exec",    L, ADDI, L, H, e(L,ADD,H,IMI,L,L,L,L,L,L,L,L));
      add("addi_wb",      L, ADDI, L, H, e(H,ADD,H,IMI,L,H,L,L,L,L,L,L));
      add("slti_fetch",   L, SLTI, L, H, fe);
      add("slti_decode",  L, SLTI, L, H, ze);
      add("slti_exec",    L, SLTI, L, H, e(L,ADD,L,IMI,L,L,L,L,L,L,L,L));
      add("slti_wb",      L, SLTI, L, H, e(H,ADD,L,IMI,L,H,L,L,L,L,L,L));
      add("beq1_fetch",   L, BEQ,  H, H, fe);
      add("beq1_decode",  L, BEQ,  H, H, ze);
      add("beq1_branch",  L, BEQ,  H, H, e(L,SUB,L,IMB,H,H,L,L,L,L,L,L));
      add("beq0_fetch",   L, BEQ,  L, H, fe);
      add("beq0_decode",  L, BEQ,  L, H, ze);
      add("beq0_branch",  L, BEQ,  L, H, e(L,SUB,L,IMB,L,H,L,L,L,L,L,L));
      add("bne1_fetch",   L, BNE,  H, H, fe);
      add("bne1_decode",  L, BNE,  H, H, ze);
      add("bne1_branch",  L, BNE,  H, H, e(L,SUB,L,IMB,L,H,L,L,L,L,L,L));
      add("bne0_fetch",   L, BNE,  L, H, fe);
      add("bne0_decode",  L, BNE,  L, H, ze);
      add("bne0_branch",  L, BNE,  L, H, e(L,SUB,L,IMB,H,H,L,L,L,L,L,L));
      add("lw_fetch_wait",L, LW,   L, L, e(L,ADD,L,IMI,L,L,L,L,H,L,L,L));
      add("lw_fetch",     L, LW,   L, H, fe);
      add("lw_decode",    L, LW,   L, L, ze);
      add("lw_memadr",    L, LW,   L, L, e(L,ADD,H,IMI,L,L,L,L,L,L,L,L));
      add("lw_memrd_w1",  L, LW,   L, L, e(L,ADD,H,IMI,L,L,L,H,H,L,L,L));
      add("lw_memrd_w2",  L, LW,   L, L, e(L,ADD,H,IMI,L,L,L,H,H,L,L,L));
      add("lw_memrd",     L, LW,   L, H, e(L,ADD,H,IMI,L,L,L,H,H,L,L,L));
      add("lw_wb",        L, LW,   L, H, e(H,ADD,H,IMI,L,H,L,L,L,L,H,L));
      add("sw_fetch",     L, SW,   L, H, fe);
      add("sw_decode",    L, SW,   L, H, ze);
      add("sw_memadr",    L, SW,   L, H, e(L,ADD,H,IMS,L,L,L,L,L,L,L,L));
      add("sw_memwr",     L, SW,   L, H, e(L,ADD,H,IMS,L,H,L,H,L,H,L,L));
      add("swr_fetch",    L, SW,   L, H, fe);
      add("swr_decode",   L, SW,   L, H, ze);
      add("swr_memadr",   L, SW,   L, H, e(L,ADD,H,IMS,L,L,L,L,L,L,L,L));
      add("swr_memwr_w",  L, SW,   L, L, e(L,ADD,H,IMS,L,L,L,H,L,H,L,L));
      add("swr_memwr_rst",H, SW,   L, L, e(L,ADD,H,IMS,L,L,L,H,L,L,L,L));
      add("ill_fetch",    L, ILL,  L, H, fe);
      add("ill_decode",   L, ILL,  L, H, ze);
      add("ill_halt",     L, ILL,  L, H, halt_e);

      rst = 1'b1; instr = ADDI; EQ = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; instr = vecs[i].instr;
         EQ  = vecs[i].eq;  mem_ready = vecs[i].rdy;
         #2;
         chk(vecs[i].name, 32'(act), 32'(vecs[i].exp));
      end

      // HALT must stay quiet whatever the memory and ALU flag do.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(1));
         EQ        = 1'($urandom_range(1));
         instr     = (k % 2 == 0) ? ADDI : SW;
         #2;
         chk($sformatf("halt_quiet_%0d", k), 32'(act), 32'(halt_e));
      end

      // Reset while halted: flag still visible, strobes masked.
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b1;
      #2;
      chk("halt_rst", 32'(act), 32'(halt_e));

      // Store with three wait cycles straight out of reset.
      stalls = 0; lat = 0; pcw_n = 0; mw_n = 0; rw_n = 0; done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            rst = 1'b0; instr = SW;
         end
         #1;
         mem_ready = !(MemWrite && stalls < 3);
         if (MemWrite && stalls < 3) stalls++;
         #1;
         if (k == 0) begin
            chk("rst_clears_illegal", 32'(illegal), 32'(0));
            chk("rst_then_fetch",     32'(IRwrite), 32'(1));
         end
         if (k > 0 && IRwrite) begin
            done = 1'b1;
            lat  = k;
            break;
         end
         pcw_n += int'(PCwrite);
         mw_n  += int'(MemWrite);
         rw_n  += int'(RegWrite);
      end
      if (!done) begin
         n_vec++;
         n_fail++;
         $display("FAIL sw_stall_timeout: no next fetch within 40 cycles, expected within 7");
      end else begin
         chk("sw_stall_latency", 32'(lat), 32'(7));
      end
      chk("sw_stall_pcwrite",  32'(pcw_n), 32'(1));
      chk("sw_stall_memwrite", 32'(mw_n),  32'(4));
      chk("sw_stall_regwrite", 32'(rw_n),  32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
